// File: rtl/ssm4_iter.sv
// ssm4_iter: multi-cycle SM4 T-transform unit, result = rs1 ^ L(tau(rs2)).
// Processes LANES S-box bytes per cycle over CYCLES = 4/LANES compute cycles.
// Supports the encrypt/decrypt (ED) and key-schedule (KS) linear layers.
//
// Ports:
//   g_clk      in   1   clock, rising edge
//   g_resetn   in   1   asynchronous active-low reset
//   in_valid   in   1   operation request
//   in_ready   out  1   unit can accept a request (registered)
//   rs1        in   32  accumulator / XOR operand
//   rs2        in   32  S-box input word
//   op_ks      in   1   select KS linear layer (wins over op_ed)
//   op_ed      in   1   select ED linear layer
//   out_valid  out  1   result available (registered)
//   out_ready  in   1   consumer accepts result
//   result     out  32  writeback value (registered, 0 outside DONE)
module ssm4_iter #(
  parameter int unsigned LANES = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        op_ks,
  input  logic        op_ed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  localparam int unsigned CYCLES = 4 / LANES;
  localparam int unsigned CNT_W  = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("ssm4_iter: LANES must be 1, 2 or 4");
  end

  // Standard SM4 S-box
  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_acc;
  logic [31:0]      r_rs2;
  logic             r_ks;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      w_contrib;
  logic             w_unused_op_ed;

  // ED is the default layer whenever op_ks is clear, so op_ed carries no extra information.
  assign w_unused_op_ed = op_ed;

  // ED linear layer
  function automatic logic [31:0] lin_ed(input logic [31:0] x);
    return x ^ {x[29:0], x[31:30]} ^ {x[21:0], x[31:22]}
             ^ {x[13:0], x[31:14]} ^ {x[7:0], x[31:8]};
  endfunction

  // KS linear layer
  function automatic logic [31:0] lin_ks(input logic [31:0] x);
    return x ^ {x[18:0], x[31:19]} ^ {x[8:0], x[31:9]};
  endfunction

  // Rotate left by whole bytes (0..3)
  function automatic logic [31:0] rol_bytes(input logic [31:0] x, input logic [1:0] n);
    logic [31:0] y;
    case (n)
      2'd1:    y = {x[23:0], x[31:24]};
      2'd2:    y = {x[15:0], x[31:16]};
      2'd3:    y = {x[7:0],  x[31:8]};
      default: y = x;
    endcase
    return y;
  endfunction

  // Contribution of one byte: rol(Lx(zext(sbox(byte))), 8*idx)
  function automatic logic [31:0] byte_contrib(input logic [31:0] w, input logic [1:0] idx,
                                               input logic ks);
    logic [7:0]  b;
    logic [31:0] z;
    b = w[{idx, 3'b000} +: 8];
    z = {24'd0, SBOX[b]};
    return rol_bytes(ks ? lin_ks(z) : lin_ed(z), idx);
  endfunction

  // XOR of this cycle's LANES contributions; lane l handles byte r_cnt*LANES + l
  always_comb begin
    w_contrib = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_contrib = w_contrib ^ byte_contrib(r_rs2, 2'(32'(r_cnt) * LANES + l), r_ks);
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_rs2     <= '0;
      r_ks      <= 1'b0;
      r_cnt     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_acc    <= rs1;
            r_rs2    <= rs2;
            r_ks     <= op_ks;
            r_cnt    <= '0;
            in_ready <= 1'b0;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc <= r_acc ^ w_contrib;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            out_valid <= 1'b1;
            result    <= r_acc ^ w_contrib;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            result    <= '0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          result    <= '0;
          in_ready  <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ssm4_iter.md
Name: ssm4_iter

Overview:
- Multi-cycle, parametrised SM4 T-transform unit for the scalar crypto datapath.
- Computes the full-word result `rs1 ^ L(tau(rs2))` in one operation: all four S-box bytes plus the linear layer.
- Supports both encrypt/decrypt (ED) and key-schedule (KS) linear layers.
- Throughput/area is set by the number of S-box lanes instantiated.
- Sits behind the functional-unit dispatcher with a valid/ready handshake on issue and on writeback.

Parameters:
- LANES, 1, S-box lanes instantiated per cycle. Legal values 1, 2, 4; any other value is an elaboration error.
- CYCLES, 4/LANES, derived localparam, not overridable. Number of compute cycles per operation.

Ports:
- g_clk  input  1  clock; all state updates on the rising edge.
- g_resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request.
- rs1  input  32  accumulator/XOR operand.
- rs2  input  32  S-box input word.
- op_ks  input  1  select KS linear layer.
- op_ed  input  1  select ED linear layer.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- result  output  32  writeback value.

Behaviour:
- Reset (async assert, sync deassert by system):
  - state=IDLE; in_ready=1; out_valid=0; result=0.
  - Internal accumulator, operand and lane counter all cleared.
- Definitions:
  - tau(w): S-box applied to each byte of w independently, using the standard SM4 S-box.
  - ED: L(B) = B ^ rol(B,2) ^ rol(B,10) ^ rol(B,18) ^ rol(B,24).
  - KS: L'(B) = B ^ rol(B,13) ^ rol(B,23).
- Mode select:
  - Latched at acceptance: KS if op_ks=1, else ED.
  - op_ks wins when both op_ks and op_ed are set.
  - Neither set means ED.
- Per-byte decomposition:
  - Byte i (0 = rs2[7:0]) contributes rol(Lx(zext(sbox(rs2 byte i))), 8*i).
  - The final result is rs1 XOR-accumulated with all four contributions.
  - Byte processing order is irrelevant to the result.
- Bytes per cycle:
  - LANES=1: cycle k processes byte k, for k = 0..3.
  - LANES=2: cycle 0 processes bytes {0,1}; cycle 1 processes bytes {2,3}.
  - LANES=4: all four bytes in one cycle.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid: latch rs1 into the accumulator, latch rs2 and the mode, set the counter to 0, go to BUSY.
  - BUSY:
    - in_ready=0.
    - Each cycle, XOR LANES contributions into the accumulator and increment the counter.
    - After the CYCLES-th update, go to DONE.
  - DONE:
    - out_valid=1; result=accumulator, held stable while out_valid=1.
    - On out_ready: out_valid drops next cycle; go to IDLE.
- Latency:
  - Acceptance at edge E0 → out_valid high after edge E0+CYCLES.
  - LANES=4 gives 1 cycle; LANES=2 gives 2; LANES=1 gives 4.
- Throughput:
  - No overlap; in_ready=0 in BUSY and DONE.
  - Minimum issue interval is CYCLES+2 cycles: accept, compute, handshake, back in IDLE.
- Boundary conditions:
  - in_valid in BUSY/DONE: ignored, no side effects.
  - Input changes in BUSY: no effect, because operands are latched.
  - out_ready held high before DONE: no effect; the handshake completes the first cycle DONE is entered.
  - Reset mid-BUSY or mid-DONE: returns to IDLE immediately; the in-flight result is discarded and out_valid drops asynchronously.
- No X propagation: result must be 0 whenever out_valid=0 after reset, until the first DONE.

Test Plan:
- ED, rs1=0x00000000, rs2=0x00000000, LANES=4 → result=0x5B5B5B5B, out_valid 1 cycle after accept.
- ED, rs1=0xFFFFFFFF, rs2=0x00000000, LANES=1 → result=0xA4A4A4A4, out_valid exactly 4 cycles after accept; in_ready=0 throughout.
- KS, rs1=0x00000000, rs2=0x00000000, LANES=2 → result=0x67676767 after 2 cycles.
- op_ks=op_ed=1, rs1=0, rs2=0 → 0x67676767 (KS priority); op_ks=op_ed=0 → 0x5B5B5B5B.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → result and out_valid stable; new in_valid with different rs2 ignored; then out_ready=1 → IDLE and in_ready=1 next cycle.
- Reset during BUSY (LANES=1, after 2 cycles): assert g_resetn=0 → out_valid=0, result=0, in_ready=1; then a fresh ED op with rs1=0, rs2=0 → 0x5B5B5B5B.
- Randomised sweep, all LANES values: result matches the golden model rs1 ^ L/L'(tau(rs2)).
